// File: rtl/invader_formation.sv
// Invader formation controller: marches a ROWS x COLS grid across the playfield,
// resolves bullet hits, speeds up on kills and levels, and reports clear/landing.
module invader_formation #(
   parameter int COLS           = 5,
   parameter int ROWS           = 4,
   parameter int FIELD_COLS     = 16,
   parameter int FIELD_ROWS     = 14,
   parameter int X_W            = 5,
   parameter int LINE_W         = 4,
   parameter int STEP_TICKS     = 30,
   parameter int MIN_STEP_TICKS = 2,
   parameter int KILL_SPEEDUP   = 1,
   parameter int LEVEL_SPEEDUP  = 4,
   parameter int LEVEL_W        = 4
) (
   input  logic                   clk_36MHz,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   tick,
   input  logic [X_W-1:0]         bullet_x,
   input  logic [LINE_W-1:0]      bullet_y,
   input  logic                   bullet_flying,
   output logic [ROWS*COLS-1:0]   invaders_array,
   output logic [X_W-1:0]         invaders_offset,
   output logic [LINE_W-1:0]      invaders_line,
   output logic                   hit,
   output logic                   cleared,
   output logic                   landed,
   output logic [LEVEL_W-1:0]     level,
   output logic                   marching
);
   localparam int N     = ROWS * COLS;
   localparam int D_W   = ((X_W > LINE_W) ? X_W : LINE_W) + 1;
   localparam int PER_W = $clog2(STEP_TICKS + 1);

   localparam logic [X_W-1:0]     MAX_OFF   = X_W'(FIELD_COLS - COLS);
   localparam logic [LINE_W-1:0]  LAND_LINE = LINE_W'(FIELD_ROWS - ROWS);
   localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_MARCH, S_CLEARED, S_LANDED} state_t;

   state_t             state;
   logic               dir_right;
   logic [PER_W-1:0]   step_cnt;
   logic [PER_W-1:0]   period;

   function automatic logic [PER_W-1:0] wave_period(input logic [LEVEL_W-1:0] lv);
      int p;
      p = STEP_TICKS - int'(lv) * LEVEL_SPEEDUP;
      if (p < MIN_STEP_TICKS) p = MIN_STEP_TICKS;
      return PER_W'(p);
   endfunction

   function automatic logic [PER_W-1:0] kill_period(input logic [PER_W-1:0] cur);
      int p;
      p = int'(cur) - KILL_SPEEDUP;
      if (p < MIN_STEP_TICKS) p = MIN_STEP_TICKS;
      return PER_W'(p);
   endfunction

   // Differences are one bit wider than either coordinate, so a bullet left of or
   // above the formation wraps to a large unsigned value and fails the range test.
   logic [D_W-1:0]     row_d, col_d;
   logic               in_grid;
   logic [N-1:0]       kill_mask;
   logic               hit_now, last_kill, step_due;
   logic [LINE_W-1:0]  line_nxt;
   logic [LEVEL_W-1:0] next_level;

   always_comb begin
      row_d     = D_W'(bullet_y) - D_W'(invaders_line);
      col_d     = D_W'(bullet_x) - D_W'(invaders_offset);
      in_grid   = (row_d < D_W'(ROWS)) && (col_d < D_W'(COLS));
      kill_mask = '0;
      if (in_grid) kill_mask = N'(1) << (int'(row_d) * COLS + int'(col_d));
      hit_now   = (state == S_MARCH) && bullet_flying && |(invaders_array & kill_mask);
      last_kill = hit_now && ((invaders_array & ~kill_mask) == '0);
      step_due  = (int'(step_cnt) + 1) >= int'(period);
      line_nxt  = invaders_line + 1'b1;
      if (state == S_CLEARED)
         next_level = (level == LEVEL_MAX) ? level : level + 1'b1;
      else
         next_level = '0;
   end

   always_ff @(posedge clk_36MHz or negedge reset) begin
      if (!reset) begin
         state           <= S_IDLE;
         invaders_array  <= '0;
         invaders_offset <= '0;
         invaders_line   <= '0;
         level           <= '0;
         hit             <= 1'b0;
         cleared         <= 1'b0;
         landed          <= 1'b0;
         marching        <= 1'b0;
         dir_right       <= 1'b1;
         step_cnt        <= '0;
         period          <= PER_W'(STEP_TICKS);
      end else begin
         hit     <= 1'b0;
         cleared <= 1'b0;
         case (state)
            S_IDLE, S_CLEARED, S_LANDED: begin
               if (start) begin
                  level           <= next_level;
                  invaders_array  <= '1;
                  invaders_offset <= '0;
                  invaders_line   <= '0;
                  dir_right       <= 1'b1;
                  step_cnt        <= '0;
                  period          <= wave_period(next_level);
                  landed          <= 1'b0;
                  marching        <= 1'b1;
                  state           <= S_MARCH;
               end
            end
            S_MARCH: begin
               // Hit is judged on the pre-step position; both updates land together.
               if (hit_now) begin
                  invaders_array <= invaders_array & ~kill_mask;
                  hit            <= 1'b1;
                  period         <= kill_period(period);
               end
               if (last_kill) begin
                  cleared  <= 1'b1;
                  marching <= 1'b0;
                  state    <= S_CLEARED;
               end else if (tick) begin
                  if (step_due) begin
                     step_cnt <= '0;
                     if (dir_right && invaders_offset < MAX_OFF)
                        invaders_offset <= invaders_offset + 1'b1;
                     else if (!dir_right && invaders_offset != '0)
                        invaders_offset <= invaders_offset - 1'b1;
                     else begin
                        invaders_line <= line_nxt;
                        dir_right     <= ~dir_right;
                        if (line_nxt == LAND_LINE) begin
                           landed   <= 1'b1;
                           marching <= 1'b0;
                           state    <= S_LANDED;
                        end
                     end
                  end else begin
                     step_cnt <= step_cnt + 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_invader_formation.sv
// Directed bench for invader_formation: march timing, hits, clear, landing, reset.
module tb_invader_formation;
   logic        clk_36MHz = 1'b0;
   logic        reset;
   logic        start, tick, bullet_flying;
   logic [4:0]  bullet_x;
   logic [3:0]  bullet_y;
   logic [19:0] invaders_array;
   logic [4:0]  invaders_offset;
   logic [3:0]  invaders_line;
   logic        hit, cleared, landed, marching;
   logic [3:0]  level;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       tag;
      logic        h;
      logic        c;
      logic [19:0] a;
   } exp_t;
   exp_t sb[$];
   logic [19:0] exp_arr;

   invader_formation dut (
      .clk_36MHz(clk_36MHz), .reset(reset), .start(start), .tick(tick),
      .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_flying(bullet_flying),
      .invaders_array(invaders_array), .invaders_offset(invaders_offset),
      .invaders_line(invaders_line), .hit(hit), .cleared(cleared), .landed(landed),
      .level(level), .marching(marching)
   );

   always #5 clk_36MHz = ~clk_36MHz;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_36MHz);
      #1;
   endtask

   task automatic ticks(input int n);
      tick = 1'b1;
      repeat (n) cyc();
      tick = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic sb_check();
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL sb_underflow: observed empty queue expected entry");
      end else begin
         e = sb.pop_front();
         check({e.tag, "_hit"}, 32'(hit), 32'(e.h));
         check({e.tag, "_cleared"}, 32'(cleared), 32'(e.c));
         check({e.tag, "_array"}, 32'(invaders_array), 32'(e.a));
      end
   endtask

   // Drive one bullet for one cycle; the expected outcome is queued before the edge.
   task automatic fire(input string tag, input int x, input int y, input int kill_bit,
                       input logic exp_clr);
      exp_t e;
      bullet_x      = 5'(x);
      bullet_y      = 4'(y);
      bullet_flying = 1'b1;
      if (kill_bit >= 0) exp_arr[kill_bit] = 1'b0;
      e.tag = tag; e.h = (kill_bit >= 0); e.c = exp_clr; e.a = exp_arr;
      sb.push_back(e);
      cyc();
      sb_check();
   endtask

   initial begin
      int k;
      reset = 1'b0; start = 1'b0; tick = 1'b0; bullet_flying = 1'b0;
      bullet_x = '0; bullet_y = '0;
      repeat (2) cyc();
      reset = 1'b1;
      cyc();
      check("rst_array", 32'(invaders_array), 0);
      check("rst_offset", 32'(invaders_offset), 0);
      check("rst_line", 32'(invaders_line), 0);
      check("rst_level", 32'(level), 0);
      check("rst_flags", {hit, cleared, landed, marching}, 0);

      // New game, march timing
      pulse_start();
      exp_arr = 20'hFFFFF;
      check("start_array", 32'(invaders_array), 32'(exp_arr));
      check("start_marching", 32'(marching), 1);
      ticks(29);
      check("tick29_offset", 32'(invaders_offset), 0);
      ticks(1);
      check("tick30_offset", 32'(invaders_offset), 1);
      pulse_start();
      check("start_in_march_offset", 32'(invaders_offset), 1);
      check("start_in_march_array", 32'(invaders_array), 32'(exp_arr));
      ticks(300);
      check("tick330_offset", 32'(invaders_offset), 11);
      check("tick330_line", 32'(invaders_line), 0);
      ticks(30);
      check("edge_line", 32'(invaders_line), 1);
      check("edge_offset", 32'(invaders_offset), 11);
      ticks(30);
      check("left_offset", 32'(invaders_offset), 10);

      // Held bullet on row 1 col 2 (bit 7): one hit only
      for (int i = 0; i < 5; i++)
         fire("held_bullet", 12, 2, (i == 0) ? 7 : -1, 1'b0);
      bullet_flying = 1'b0;
      ticks(28);
      check("period29_before", 32'(invaders_offset), 10);
      ticks(1);
      check("period29_step", 32'(invaders_offset), 9);

      // Out-of-grid bullets, then a corner hit (row 3 col 4 = bit 19)
      fire("x_underflow", 8, 1, -1, 1'b0);
      fire("y_below", 9, 5, -1, 1'b0);
      fire("x_right", 14, 1, -1, 1'b0);
      fire("corner", 13, 4, 19, 1'b0);
      bullet_flying = 1'b0;

      // Asynchronous reset mid-march
      @(posedge clk_36MHz);
      #3 reset = 1'b0;
      #1;
      check("async_rst_array", 32'(invaders_array), 0);
      check("async_rst_pos", {invaders_offset, invaders_line}, 0);
      check("async_rst_flags", {hit, cleared, landed, marching}, 0);
      check("async_rst_level", 32'(level), 0);
      cyc();
      reset = 1'b1;
      cyc();

      // Kill the whole wave
      pulse_start();
      exp_arr = 20'hFFFFF;
      for (int i = 0; i < 20; i++)
         fire("kill_all", i % 5, i / 5, i, i == 19);
      bullet_flying = 1'b0;
      check("cleared_marching", 32'(marching), 0);
      cyc();
      check("cleared_pulse_end", {hit, cleared}, 0);
      ticks(40);
      fire("bullet_in_cleared", 0, 0, -1, 1'b0);
      bullet_flying = 1'b0;
      check("cleared_frozen", {invaders_offset, invaders_line}, 0);
      pulse_start();
      check("level1", 32'(level), 1);
      check("level1_array", 32'(invaders_array), 32'hFFFFF);
      ticks(25);
      check("period26_before", 32'(invaders_offset), 0);
      ticks(1);
      check("period26_step", 32'(invaders_offset), 1);

      // Landing at level 0: line L is reached on step 12*L, so line 10 after 3600 ticks
      reset = 1'b0;
      #2 reset = 1'b1;
      cyc();
      pulse_start();
      k = 0;
      tick = 1'b1;
      while (k < 5000 && !landed) begin
         cyc();
         k++;
      end
      tick = 1'b0;
      check("land_ticks", 32'(k), 3600);
      check("land_line", 32'(invaders_line), 10);
      check("land_offset", 32'(invaders_offset), 0);
      check("land_marching", 32'(marching), 0);
      ticks(50);
      check("land_hold", {landed, 3'b0, invaders_line, 3'b0, invaders_offset}, {1'b1, 3'b0, 4'd10, 3'b0, 5'd0});
      pulse_start();
      check("restart_level", 32'(level), 0);
      check("restart_landed", 32'(landed), 0);
      check("restart_array", 32'(invaders_array), 32'hFFFFF);
      check("restart_line", 32'(invaders_line), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/invader_formation.md
# invader_formation

Parametrised successor to the fixed 20-invader controller. It owns a ROWS×COLS grid of invaders and marches it across and down the playfield in the classic pattern. It resolves player-bullet hits, speeds up as invaders die, and tracks the level, signalling when the wave is cleared or the formation has landed. It sits between `player` (bullet position in) and `sprite_drawer` (grid, offset and line out), clocked from the 36 MHz pixel clock.

## Interface
- COLS, 5, invaders per row
- ROWS, 4, invader rows; `invaders_array` width is ROWS*COLS
- FIELD_COLS, 16, playfield width in grid columns; COLS ≤ FIELD_COLS ≤ 2**X_W
- FIELD_ROWS, 14, playfield height in grid lines; landing line is FIELD_ROWS-ROWS
- X_W, 5, width of column coordinates (`bullet_x`, `invaders_offset`)
- LINE_W, 4, width of line coordinates (`bullet_y`, `invaders_line`)
- STEP_TICKS, 30, frame ticks per march step at level 0
- MIN_STEP_TICKS, 2, floor on step period
- KILL_SPEEDUP, 1, step-period decrement per kill
- LEVEL_SPEEDUP, 4, step-period decrement per level at wave start
- LEVEL_W, 4, level counter width

Ports:
- clk_36MHz  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  debounced start pulse (one cycle)
- tick  in  1  frame strobe, one cycle per frame
- bullet_x  in  X_W  bullet column
- bullet_y  in  LINE_W  bullet line
- bullet_flying  in  1  bullet valid
- invaders_array  out  ROWS*COLS  alive mask; bit r*COLS+c is row r, column c
- invaders_offset  out  X_W  grid column of formation column 0
- invaders_line  out  LINE_W  grid line of formation row 0
- hit  out  1  one-cycle pulse: bullet killed an invader
- cleared  out  1  one-cycle pulse: wave destroyed
- landed  out  1  level: formation reached landing line (game over)
- level  out  LEVEL_W  current level
- marching  out  1  high in MARCH state

## Operation
- States: IDLE, MARCH, CLEARED, LANDED.
- IDLE/LANDED + `start` → new game: level=0, then wave init. CLEARED + `start` → level+1 (saturating at 2**LEVEL_W-1), then wave init. `start` in MARCH is ignored.
- Wave init: array all ones, offset=0, line=0, direction=right, tick count=0, period=max(MIN_STEP_TICKS, STEP_TICKS − level*LEVEL_SPEEDUP). Next state is MARCH.
- March: in MARCH, each `tick` increments the count. When the count reaches period−1 on a tick, the count resets and one step is taken:
  - Right and offset < FIELD_COLS−COLS → offset+1.
  - Left and offset > 0 → offset−1.
  - Otherwise (at edge) → line+1 and the direction reverses; offset is unchanged.
- Landing: a step that makes line = FIELD_ROWS−ROWS → LANDED; `landed`=1 until the next `start`.
- Hit: in MARCH with `bullet_flying`, compute r = bullet_y − line and c = bullet_x − offset using the current registered values. A hit occurs when 0≤r<ROWS, 0≤c<COLS and bit r*COLS+c = 1. On a hit, that bit is cleared, `hit` pulses, and period = max(MIN_STEP_TICKS, period − KILL_SPEEDUP).
- Compute differences at width max(X_W, LINE_W)+1 so that negative values are rejected.
- Clear: when a hit removes the last set bit → CLEARED, and `cleared` pulses in the same cycle as `hit`. Array stays zero and offset/line freeze.
- Simultaneous hit and step: the hit is judged against pre-step position, and both updates apply on the same edge.
- Simultaneous last kill and landing step: CLEARED wins and `landed` stays 0.
- Outside MARCH: bullets and ticks are ignored, and the array/offset/line hold their values.

## Timing
- Reset values: array=0, offset=0, line=0, level=0, hit=0, cleared=0, landed=0, marching=0, state IDLE, direction right, count 0, period STEP_TICKS.
- Reset is asynchronous at assertion. All other behaviour is registered on the rising edge of `clk_36MHz`.
- `start` sampled at edge N → MARCH, with full array visible after edge N.
- Bullet inputs sampled at edge N → bit cleared and `hit`=1 during cycle N+1 (one-cycle latency, one-cycle pulse).
- A bullet held on the same cell produces exactly one `hit`.
- Step: the tick completing the period at edge N → new offset/line after edge N. Exactly period ticks separate consecutive steps.
- Period changes take effect on the count comparison in the cycle after the change. If count ≥ new period−1, the next tick steps.

## Test plan
- Reset mid-MARCH: drive `reset`=0 asynchronously → all outputs are at their reset values before the next clock edge; state is IDLE.
- Defaults, `start`, 30 ticks → offset=1. After 330 ticks offset=11; the next step gives line=1 with offset 11, then offset decrements.
- Bullet at (x=offset+2, y=line+1) with `bullet_flying` held 5 cycles → bit 7 cleared, exactly one `hit` pulse one cycle after sampling, step period 29.
- Bullet at x=offset−1 (underflow) or y=line+4 → no hit, array unchanged.
- Kill all 20 invaders → `cleared` pulses with the 20th `hit`, state CLEARED; `start` → level=1, full array, period 26.
- Never shoot, defaults → `landed` rises on the step that sets line=10; further ticks change nothing; `start` → level=0, new wave.
